// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle add/logic/compare, iterative 1-bit-per-cycle shifts,
// valid/ready handshakes on both sides with a registered result held until accepted.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alu_fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             neg,
  output logic             bad_op
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             bad_op_q, bad_op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [1:0]       sh_op_q, sh_op_d;

  // Single-cycle evaluation of the presented operands; only consumed at the accept edge.
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] imm_res;
  logic             imm_ovf, imm_bad, imm_shift, cond;
  logic [SHW-1:0]   amt;

  assign sum  = a + b;
  assign diff = a - b;
  assign amt  = a[SHW-1:0];

  // NOTE: every signal written in a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    imm_res   = '0;
    imm_ovf   = 1'b0;
    imm_bad   = 1'b0;
    imm_shift = 1'b0;
    cond      = 1'b0;
    unique case (alu_fun[5:4])
      2'b00: begin
        if (alu_fun[0]) begin
          imm_res = diff;
          imm_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end else begin
          imm_res = sum;
          imm_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
      end
      2'b01: begin
        case (alu_fun[3:0])
          4'b1000: imm_res = a & b;
          4'b1110: imm_res = a | b;
          4'b0110: imm_res = a ^ b;
          4'b0001: imm_res = ~(a | b);
          4'b1010: imm_res = a;
          default: imm_bad = 1'b1;
        endcase
      end
      2'b10: begin
        // A zero shift amount completes immediately with the data operand unchanged.
        if (alu_fun[1:0] == 2'b10) begin
          imm_bad = 1'b1;
        end else begin
          imm_shift = 1'b1;
          imm_res   = b;
        end
      end
      default: begin
        case (alu_fun[3:1])
          3'b001:  cond = (a == b);
          3'b000:  cond = (a != b);
          3'b010:  cond = alu_fun[0] ? ($signed(a) < $signed(b)) : (a < b);
          3'b110:  cond = a[WIDTH-1] || (a == '0);
          3'b100:  cond = a[WIDTH-1];
          3'b111:  cond = !a[WIDTH-1] && (a != '0);
          default: imm_bad = 1'b1;
        endcase
        imm_res = {{(WIDTH-1){1'b0}}, cond};
      end
    endcase
    if (imm_bad) begin
      imm_res = '0;
    end
  end

  logic [WIDTH-1:0] work_step;

  always_comb begin
    unique case (sh_op_q)
      SH_SLL:  work_step = {work_q[WIDTH-2:0], 1'b0};
      SH_SRL:  work_step = {1'b0, work_q[WIDTH-1:1]};
      SH_SRA:  work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: work_step = work_q;
    endcase
  end

  logic             load;
  logic [WIDTH-1:0] load_res;
  logic             load_ovf, load_bad;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    bad_op_d = bad_op_q;
    work_d   = work_q;
    count_d  = count_q;
    sh_op_d  = sh_op_q;
    load     = 1'b0;
    load_res = '0;
    load_ovf = 1'b0;
    load_bad = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (imm_shift && (amt != '0)) begin
            work_d  = b;
            count_d = amt;
            sh_op_d = alu_fun[1:0];
            state_d = S_SHIFT;
          end else begin
            load     = 1'b1;
            load_res = imm_res;
            load_ovf = imm_ovf;
            load_bad = imm_bad;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        work_d  = work_step;
        count_d = count_q - 1'b1;
        if (count_q == SHW'(1)) begin
          load     = 1'b1;
          load_res = work_step;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flags are derived once from the final value so they always agree with result.
    if (load) begin
      result_d = load_res;
      zero_d   = (load_res == '0);
      neg_d    = load_res[WIDTH-1];
      ovf_d    = load_ovf;
      bad_op_d = load_bad;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      bad_op_q <= 1'b0;
      work_q   <= '0;
      count_q  <= '0;
      sh_op_q  <= SH_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      bad_op_q <= bad_op_d;
      work_q   <= work_d;
      count_q  <= count_d;
      sh_op_q  <= sh_op_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign neg       = neg_q;
  assign bad_op    = bad_op_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner cases plus randomized operations
// compared against an arithmetic reference model (value, flags and latency).
module tb_alu_exec;

  localparam int W = 32;
  localparam longint MAXS = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W-1));

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   alu_fun;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, ovf, neg, bad_op;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_fun(alu_fun), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .neg(neg), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         bad;
    int           lat;
  } exp_t;

  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t   e;
    longint s;
    int     amt;
    logic   c;
    e.res = '0; e.ovf = 1'b0; e.bad = 1'b0; e.lat = 1;
    c = 1'b0;
    case (f[5:4])
      2'b00: begin
        s = f[0] ? longint'($signed(av)) - longint'($signed(bv))
                 : longint'($signed(av)) + longint'($signed(bv));
        e.res = s[W-1:0];
        e.ovf = (s > MAXS) || (s < MINS);
      end
      2'b01: begin
        case (f[3:0])
          4'b1000: e.res = av & bv;
          4'b1110: e.res = av | bv;
          4'b0110: e.res = av ^ bv;
          4'b0001: e.res = ~(av | bv);
          4'b1010: e.res = av;
          default: e.bad = 1'b1;
        endcase
      end
      2'b10: begin
        amt = int'(av % W);
        case (f[1:0])
          2'b00:   e.res = bv << amt;
          2'b01:   e.res = bv >> amt;
          2'b11:   e.res = $signed(bv) >>> amt;
          default: e.bad = 1'b1;
        endcase
        if (!e.bad) e.lat = 1 + amt;
      end
      default: begin
        case (f[3:1])
          3'b001:  c = (av == bv);
          3'b000:  c = (av != bv);
          3'b010:  c = f[0] ? ($signed(av) < $signed(bv)) : (av < bv);
          3'b110:  c = ($signed(av) <= 0);
          3'b100:  c = ($signed(av) < 0);
          3'b111:  c = ($signed(av) > 0);
          default: e.bad = 1'b1;
        endcase
        e.res = W'(c);
      end
    endcase
    if (e.bad) e.res = '0;
    return e;
  endfunction

  // Issue one op, verify latency/value/flags, optionally stall the consumer, then hand off.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int hold);
    exp_t e;
    int   cyc;
    e = model(f, av, bv);
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".in_ready"}, in_ready, 1'b1);
    alu_fun  = f;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge; the op in flight must not notice.
    alu_fun  = 6'($urandom);
    a        = $urandom;
    b        = $urandom;
    in_valid = 1'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 2*W + 4);
    check({tag, ".latency"}, cyc, e.lat);
    check({tag, ".result"}, result, e.res);
    check({tag, ".zero"}, zero, (e.res == '0));
    check({tag, ".ovf"}, ovf, e.ovf);
    check({tag, ".neg"}, neg, e.res[W-1]);
    check({tag, ".bad_op"}, bad_op, e.bad);
    check({tag, ".in_ready_done"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, out_valid, 1'b1);
      check({tag, ".hold_result"}, result, e.res);
      check({tag, ".hold_ovf"}, ovf, e.ovf);
      check({tag, ".hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, ".handoff_valid"}, out_valid, 1'b0);
    check({tag, ".handoff_ready"}, in_ready, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    check({tag, ".out_valid"}, out_valid, 1'b0);
    check({tag, ".outputs"}, {result, zero, ovf, neg, bad_op}, '0);
  endtask

  logic [5:0] codes[18] = '{6'h00, 6'h01, 6'h18, 6'h1E, 6'h16, 6'h11, 6'h1A,
                            6'h20, 6'h21, 6'h23, 6'h32, 6'h30, 6'h35, 6'h34,
                            6'h3C, 6'h38, 6'h3E, 6'h3B};

  initial begin
    int         cyc;
    logic       seen;
    logic [5:0] f;
    logic [W-1:0] av, bv;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_fun = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    run_op("add_ovf",  6'h00, 32'h7FFF_FFFF, 32'h0000_0001, 3);
    run_op("sub_zero", 6'h01, 32'd5, 32'd5, 0);
    run_op("eq",       6'h32, 32'd3, 32'd3, 0);
    run_op("sra4",     6'h23, 32'd4, 32'h8000_0000, 1);
    run_op("sll0",     6'h20, 32'd0, 32'd1, 0);
    run_op("lt_s",     6'h35, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("lt_u",     6'h34, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("gtz0",     6'h3E, 32'd0, 32'd0, 0);
    run_op("bad3b",    6'h3B, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("srl31",    6'h21, 32'd31, 32'hFFFF_FFFF, 0);
    run_op("sub_ovf",  6'h01, 32'h8000_0000, 32'd1, 2);

    // Reset in the middle of a 20-bit shift discards it.
    @(negedge clk);
    alu_fun = 6'h20; a = 32'd20; b = 32'h0000_0001; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midshift.busy", out_valid, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("midshift_reset");
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midshift.discarded", seen, 1'b0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(3) != 0) f = codes[$urandom_range(17)];
      else f = 6'($urandom);
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(5))
        0: bv = av;
        1: av = '0;
        2: av = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%02h", n, f), f, av, bv, $urandom_range(2));
    end

    cyc = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
